// File: rtl/aes256_inv_key_sched_pkg.sv
// Shared widths, FSM encoding, rcon lookup and GF(2^8) helpers for the AES-256 inverse key schedule.
// Defining INV_KS_EQINV_EN adds the InvMixColumns helper used for equivalent-inverse-cipher keys.
package aes256_inv_key_sched_pkg;

    localparam int WORD_W = 32;
    localparam int KEY_W  = 256;
    localparam int RK_W   = 128;
    localparam int NWIN   = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_OUT  = 2'd1;
    localparam state_t ST_CALC = 2'd2;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

`ifdef INV_KS_EQINV_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
                gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
                gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
                gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] k);
        return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
                inv_mix_col(k[63:32]),  inv_mix_col(k[31:0])};
    endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box computed as GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox
    import aes256_inv_key_sched_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] x2, x3, x6, x12, x15, x240, inv;

    always_comb begin
        x2   = gf_mul(din, din);
        x3   = gf_mul(x2, din);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        // 240 + 12 + 2 = 254; zero maps to zero as required
        inv  = gf_mul(gf_mul(x240, x12), x2);
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes256_inv_key_sched.sv
// AES-256 inverse key schedule: streams round keys 14..0 from the last eight expanded words.
// Optional INV_KS_EQINV_EN emits InvMixColumns'd keys for rounds 1..13 (equivalent inverse cipher).
module aes256_inv_key_sched
    import aes256_inv_key_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              rk_ready,
    output logic              rk_valid,
    output logic [RK_W-1:0]   rk,
    output logic [3:0]        rk_idx,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [WORD_W-1:0] win [NWIN];
    logic [3:0]        idx;
    logic              done_q;
    logic              hs;
    logic [WORD_W-1:0] sub_in, sub_out, t0;
    logic [WORD_W-1:0] new_w [4];
    logic [3:0]        rc_idx;
    logic [RK_W-1:0]   raw_rk;

    // Handshake: rk/rk_idx transfer on a rising edge where rk_valid & rk_ready; while
    // rk_valid is high and rk_ready low, rk, rk_idx and rk_valid hold unchanged.
    assign rk_valid = (state == ST_OUT);
    assign hs       = rk_valid & rk_ready;
    assign busy     = (state != ST_IDLE);
    assign done     = done_q;
    assign rk_idx   = idx;

    // Producing round m = idx-1: even m (odd idx) takes RotWord plus rcon, odd m SubWord only
    assign sub_in = idx[0] ? {win[3][23:0], win[3][31:24]} : win[3];

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (sub_in[8*g +: 8]),
            .dout (sub_out[8*g +: 8])
        );
    end

    assign rc_idx   = ((idx - 4'd1) >> 1) + 4'd1;
    assign t0       = sub_out ^ (idx[0] ? {rcon(rc_idx), 24'h0} : 32'h0);
    assign new_w[0] = win[4] ^ t0;
    assign new_w[1] = win[5] ^ win[4];
    assign new_w[2] = win[6] ^ win[5];
    assign new_w[3] = win[7] ^ win[6];

    assign raw_rk = (idx == 4'd14) ? {win[4], win[5], win[6], win[7]}
                                   : {win[0], win[1], win[2], win[3]};

`ifdef INV_KS_EQINV_EN
    assign rk = (idx != 4'd0 && idx != 4'd14) ? inv_mix(raw_rk) : raw_rk;
`else
    assign rk = raw_rk;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < NWIN; i++) win[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_OUT;
                        idx   <= 4'd14;
                        for (int i = 0; i < NWIN; i++)
                            win[i] <= key_in[KEY_W-1-WORD_W*i -: WORD_W];
                    end
                end
                ST_OUT: begin
                    if (hs) begin
                        if (idx == 4'd14) begin
                            idx <= 4'd13;
                        end else if (idx == 4'd0) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    for (int i = 0; i < 4; i++) begin
                        win[i]   <= new_w[i];
                        win[i+4] <= win[i];
                    end
                    idx   <= idx - 4'd1;
                    state <= ST_OUT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
